// File: rtl/spi_master_if.sv
// Command/response bundle between a host and the SPI initiator.
// Signals: cmd_valid/cmd_ready/cmd_data in, rsp_valid/rsp_data/busy back.
interface spi_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [9:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy;

   modport master (
      output cmd_valid, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: 10-bit commands out on mosi, 8-bit read reply in.
// Ports: clk, rst_n (sync, low), cmd (if slave side), sclk, ss_n, mosi, miso.
module spi_master #(
   parameter int CLK_DIV     = 2,
   parameter int TURN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   spi_master_if.slave cmd,
   output logic        sclk,
   output logic        ss_n,
   output logic        mosi,
   input  logic        miso
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SHIFT_CMD = 3'd1;
   localparam logic [2:0] TURN      = 3'd2;
   localparam logic [2:0] SHIFT_RSP = 3'd3;
   localparam logic [2:0] END       = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] hcnt;
   logic [3:0]    bcnt;
   logic [TW-1:0] tcnt;
   logic [9:0]    sh;
   logic [7:0]    rx;
   logic          rd;
   logic          rsp_valid_q;
   logic [7:0]    rsp_data_q;

   logic wrap;
   logic rise;
   logic fall;

   always_comb begin
      wrap = (hcnt == CW'(CLK_DIV - 1));
      rise = wrap & ~sclk;
      fall = wrap & sclk;
   end

   assign cmd.cmd_ready = (state == IDLE);
   assign cmd.busy      = (state != IDLE);
   assign cmd.rsp_valid = rsp_valid_q;
   assign cmd.rsp_data  = rsp_data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         hcnt        <= '0;
         bcnt        <= '0;
         tcnt        <= '0;
         sh          <= '0;
         rx          <= '0;
         rd          <= 1'b0;
         sclk        <= 1'b0;
         ss_n        <= 1'b1;
         mosi        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         // Half-period counter free-runs in every non-idle state;
         // END reuses it to time the ss_n high gap.
         if (state != IDLE)
            hcnt <= wrap ? '0 : hcnt + CW'(1);
         case (state)
            IDLE: begin
               if (cmd.cmd_valid) begin
                  sh    <= cmd.cmd_data;
                  rd    <= &cmd.cmd_data[9:8];
                  ss_n  <= 1'b0;
                  mosi  <= cmd.cmd_data[9];
                  hcnt  <= '0;
                  bcnt  <= '0;
                  state <= SHIFT_CMD;
               end
            end
            SHIFT_CMD: begin
               if (wrap)
                  sclk <= ~sclk;
               if (fall) begin
                  if (bcnt == 4'd9) begin
                     mosi <= 1'b0;
                     bcnt <= '0;
                     tcnt <= '0;
                     if (rd) begin
                        state <= TURN;
                     end else begin
                        ss_n  <= 1'b1;
                        state <= END;
                     end
                  end else begin
                     bcnt <= bcnt + 4'd1;
                     mosi <= sh[8];
                     sh   <= {sh[8:0], 1'b0};
                  end
               end
            end
            TURN: begin
               if (wrap)
                  sclk <= ~sclk;
               if (fall) begin
                  if (tcnt == TW'(TURN_CYCLES - 1)) begin
                     bcnt  <= '0;
                     state <= SHIFT_RSP;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
            end
            SHIFT_RSP: begin
               if (wrap)
                  sclk <= ~sclk;
               if (rise)
                  rx <= {rx[6:0], miso};
               if (fall) begin
                  if (bcnt == 4'd7) begin
                     ss_n        <= 1'b1;
                     rsp_data_q  <= rx;
                     rsp_valid_q <= 1'b1;
                     state       <= END;
                  end else begin
                     bcnt <= bcnt + 4'd1;
                  end
               end
            end
            END: begin
               if (wrap)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_master.md
# spi_master

Host-side SPI initiator that drives the SPI slave + single-port RAM subsystem over its serial pins. Accepts 10-bit commands (2-bit opcode + 8-bit payload) on a valid/ready interface, serializes them MSB-first on MOSI under a divided SCLK. For opcode 2'b11 (read data), it holds the frame open, supplies turnaround clocks, and captures the 8-bit reply from MISO. Sits at the test/host end of the link; it is the initiator counterpart to the slave/RAM responder.

## Interface
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range ≥1.
- TURN_CYCLES, 2, full SCLK periods between command and reply on read-data frames; legal range ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present; cmd_data held stable until accepted.
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready on a clk edge.
- cmd_data  in  10  [9:8] opcode (00 wr addr, 01 wr data, 10 rd addr, 11 rd data), [7:0] payload.
- rsp_valid  out  1  one-cycle pulse with captured read byte.
- rsp_data  out  8  last read byte; holds until next read completes.
- busy  out  1  ~cmd_ready.
- sclk  out  1  serial clock, idle low (mode 0).
- ss_n  out  1  slave select, active-low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

## Operation
- All outputs registered except cmd_ready/busy, which decode state.
- Reset values: ss_n=1, sclk=0, mosi=0, rsp_valid=0, rsp_data=8'h00, state=IDLE (cmd_ready=1, busy=0).
- States: IDLE, SHIFT_CMD, TURN, SHIFT_RSP, END.
- IDLE: on accept, latch cmd_data into 10-bit shift reg, ss_n←0, mosi←cmd_data[9], half-period counter←0, → SHIFT_CMD.
- Half-period counter counts 0..CLK_DIV-1. On wrap, sclk toggles. A toggle 0→1 is a "rise"; a toggle 1→0 is a "fall".
- SHIFT_CMD: each fall shifts the next bit onto mosi. On the 10th fall: mosi←0; if latched opcode==2'b11, → TURN; else ss_n←1, sclk stays 0, → END.
- TURN: mosi=0; SCLK runs TURN_CYCLES full periods. On the last fall, → SHIFT_RSP.
- SHIFT_RSP: on each rise, sample miso into the rx shift reg, MSB first. On the 8th fall: ss_n←1, rsp_data←assembled byte, rsp_valid←1 for exactly one cycle, → END.
- END: ss_n=1, sclk=0 for CLK_DIV cycles, then → IDLE.
- Opcodes 00/01/10 never produce rsp_valid. rsp_data is unchanged by them.
- cmd_valid while busy: ignored; no queuing.
- Reset mid-frame: at the next edge with rst_n=0, all reset values apply. The frame is aborted, no rsp_valid is produced, and rsp_data clears to 0.
- Bit counters: 4-bit, counting 0..9 and 0..7. Turnaround counter is sized for TURN_CYCLES. No wrap beyond terminal counts.

## Timing
- Accept at edge 0: ss_n low and mosi=bit9 are visible after edge 0.
- First rise at edge CLK_DIV; bit k is stable across its rise.
- Non-read frame: ss_n low for exactly 20·CLK_DIV cycles. cmd_ready returns CLK_DIV cycles after ss_n rises.
- Read frame: ss_n low for (20 + 2·TURN_CYCLES + 16)·CLK_DIV cycles. rsp_valid pulses in the first cycle ss_n is high.
- Minimum ss_n high gap between back-to-back frames: CLK_DIV+1 cycles, with cmd_valid held high.
- Miso is sampled from its value at the clk edge that raises sclk. The slave changes miso only after a fall.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with cmd_valid=1 and miso toggling -> ss_n=1, sclk=0, mosi=0, rsp_valid=0, rsp_data=0, cmd_ready=1 throughout.
- Write-address frame, CLK_DIV=2, cmd 10'h0A5 -> at 10 successive rises mosi = 0,0,1,0,1,0,0,1,0,1; ss_n low exactly 40 cycles; no rsp_valid; cmd_ready high 2 cycles after ss_n rises.
- Read-data frame, CLK_DIV=2, TURN_CYCLES=2, cmd 10'h300, slave model returns 8'h5A -> ss_n low 80 cycles; exactly one rsp_valid pulse with rsp_data=8'h5A; mosi=0 during TURN and SHIFT_RSP.
- Back-to-back: cmd_valid held with 10'h1C3 then 10'h0FF -> second frame starts exactly CLK_DIV+1 cycles after ss_n rises; bit streams correct for both; cmd_ready low for the entire frame.
- Reset mid-read: assert rst_n=0 during SHIFT_RSP (cycle 60 of a 10'h300 frame) -> next edge ss_n=1, sclk=0; no rsp_valid; a subsequent read returning 8'hC3 completes normally.
- CLK_DIV=1, read of 8'hFF then a write 10'h155 -> sclk = clk/2; rsp_data=8'hFF; write frame ss_n low 20 cycles; rsp_data still 8'hFF after the write.
